// File: rtl/imm_pkg.sv
// imm_pkg: shared mode encodings and default widths for the immediate-extension unit.
package imm_pkg;
   localparam logic [1:0] MODE_SEXT     = 2'b00;
   localparam logic [1:0] MODE_ZEXT     = 2'b01;
   localparam logic [1:0] MODE_SEXT_SHL = 2'b10;
   localparam logic [1:0] MODE_UPPER    = 2'b11;
   localparam int IMM_IN_W  = 16;
   localparam int IMM_OUT_W = 32;
   localparam int IMM_SHL   = 2;
endpackage

// File: rtl/skid_buf_2.sv
// skid_buf_2: 2-entry FIFO with valid/ready on both sides; in_ready comes only from the registered count.
module skid_buf_2 #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic [1:0]   count_q, count_d;
   logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic         push, pop;
   assign in_ready  = count_q != 2'd2;
   assign out_valid = count_q != 2'd0;
   assign out_data  = e0_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   // e0 is always the oldest entry; e1 only fills when e0 is occupied and not leaving
   always_comb begin
      e0_d    = ((count_q == 2'd0 && push) || (count_q == 2'd1 && push && pop)) ? in_data :
                (count_q == 2'd2 && pop) ? e1_q : e0_q;
      e1_d    = (count_q == 2'd1 && push && !pop) ? in_data : e1_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         e0_q    <= '0;
         e1_q    <= '0;
      end else begin
         count_q <= count_d;
         e0_q    <= e0_d;
         e1_q    <= e1_d;
      end
   end
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: widens an immediate by mode (sext/zext/sext<<SHL/upper) and registers it into a 2-entry skid buffer.
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W,
   parameter int SHL   = IMM_SHL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
);
   if (IN_W < 1 || IN_W > OUT_W || SHL < 0 || SHL >= OUT_W) begin : g_bad_params
      $error("imm_extend_pipe: illegal IN_W/OUT_W/SHL combination");
   end
   logic [OUT_W-1:0] sext, zext, ext;
   // size casts avoid zero-width replications when IN_W == OUT_W
   always_comb begin
      sext = OUT_W'($signed(in_data));
      zext = OUT_W'(in_data);
      ext  = (in_mode == MODE_SEXT)     ? sext :
             (in_mode == MODE_ZEXT)     ? zext :
             (in_mode == MODE_SEXT_SHL) ? sext << SHL :
                                          zext << (OUT_W - IN_W);
   end
   skid_buf_2 #(.W(OUT_W)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (ext),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed table plus backpressure and async-reset sequences for imm_extend_pipe.
module tb_imm_extend_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   int          errors = 0;
   int          checks = 0;
   typedef struct {
      logic [1:0]  mode;
      logic [15:0] data;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [15];
   always #5 clk = ~clk;
   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHL(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] d);
      in_valid = v;
      in_mode  = m;
      in_data  = d;
   endtask
   initial begin
      vecs[0]  = '{2'b00, 16'h8888, 32'hFFFF8888};
      vecs[1]  = '{2'b00, 16'h7FFF, 32'h00007FFF};
      vecs[2]  = '{2'b01, 16'h8888, 32'h00008888};
      vecs[3]  = '{2'b11, 16'h1234, 32'h12340000};
      vecs[4]  = '{2'b10, 16'hFFFF, 32'hFFFFFFFC};
      vecs[5]  = '{2'b10, 16'h4000, 32'h00010000};
      vecs[6]  = '{2'b10, 16'h8000, 32'hFFFE0000};
      vecs[7]  = '{2'b01, 16'hFFFF, 32'h0000FFFF};
      vecs[8]  = '{2'b11, 16'hFFFF, 32'hFFFF0000};
      vecs[9]  = '{2'b00, 16'h0000, 32'h00000000};
      vecs[10] = '{2'b10, 16'h0001, 32'h00000004};
      vecs[11] = '{2'b11, 16'h8001, 32'h80010000};
      vecs[12] = '{2'b00, 16'h8000, 32'hFFFF8000};
      vecs[13] = '{2'b01, 16'h0000, 32'h00000000};
      vecs[14] = '{2'b10, 16'h7FFF, 32'h0001FFFC};
      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 2'b00, 16'h0);
      repeat (2) @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data", out_data, 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      // back-to-back stream: each result checked one cycle after its input is offered
      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, vecs[i].mode, vecs[i].data);
         @(negedge clk);
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d out_data", i), out_data, vecs[i].exp);
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      end
      drive(1'b0, 2'b00, 16'h0);
      @(negedge clk);
      chk("drain out_valid", 32'(out_valid), 32'd0);
      // backpressure
      out_ready = 1'b0;
      drive(1'b1, 2'b00, 16'h0001);
      @(negedge clk);
      chk("bp A valid", 32'(out_valid), 32'd1);
      chk("bp A data", out_data, 32'h1);
      chk("bp A in_ready", 32'(in_ready), 32'd1);
      drive(1'b1, 2'b00, 16'h0002);
      @(negedge clk);
      chk("bp full in_ready", 32'(in_ready), 32'd0);
      chk("bp full data", out_data, 32'h1);
      drive(1'b1, 2'b00, 16'h0003);
      @(negedge clk);
      chk("bp hold in_ready", 32'(in_ready), 32'd0);
      chk("bp hold data", out_data, 32'h1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp pop B data", out_data, 32'h2);
      chk("bp pop in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("bp C data", out_data, 32'h3);
      chk("bp C valid", 32'(out_valid), 32'd1);
      drive(1'b0, 2'b00, 16'h0);
      @(negedge clk);
      chk("bp empty valid", 32'(out_valid), 32'd0);
      // async reset with two entries held
      out_ready = 1'b0;
      drive(1'b1, 2'b01, 16'h00AA);
      @(negedge clk);
      drive(1'b1, 2'b01, 16'h00BB);
      @(negedge clk);
      drive(1'b0, 2'b00, 16'h0);
      chk("pre-rst in_ready", 32'(in_ready), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("async rst out_valid", 32'(out_valid), 32'd0);
      chk("async rst out_data", out_data, 32'd0);
      chk("async rst in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 2'b01, 16'hFFFF);
      @(negedge clk);
      drive(1'b0, 2'b00, 16'h0);
      chk("post-rst valid", 32'(out_valid), 32'd1);
      chk("post-rst data", out_data, 32'h0000FFFF);
      @(negedge clk);
      chk("post-rst drain", 32'(out_valid), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
